// File: rtl/fft_accel_pkg.sv
// Shared types and defaults for the fft_accel job sequencer.
package fft_accel_pkg;

  localparam int DEFAULT_BEATS = 64;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_WAIT,
    ST_FILT,
    ST_WAITF,
    ST_UNLOAD,
    ST_DRAIN,
    ST_RESP
  } ctrl_state_t;

  typedef enum logic [1:0] {
    OP_FFT      = 2'd0,
    OP_IFFT     = 2'd1,
    OP_FFT_FILT = 2'd2,
    OP_RSVD     = 2'd3
  } fft_op_t;

  typedef enum logic [1:0] {
    ERR_OK      = 2'd0,
    ERR_TIMEOUT = 2'd1,
    ERR_BAD_OP  = 2'd2
  } resp_err_t;

endpackage

// File: rtl/ctrl_counter.sv
// Up-counter with synchronous clear/load and saturation at MAXVAL.
module ctrl_counter #(
  parameter int WIDTH  = 8,
  parameter int MAXVAL = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] loadVal,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] SAT = WIDTH'(MAXVAL);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (load) begin
      count <= loadVal;
    end else if (en && (count != SAT)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/fft_accel_ctrl.sv
// Job sequencer for fft_accel: loads input beats, fires start/filter
// pulses, waits for done with a timeout, drains the output FIFO, responds.
module fft_accel_ctrl
  import fft_accel_pkg::*;
#(
  parameter int BEATS   = DEFAULT_BEATS,
  parameter int TIMEOUT = 65535,
  parameter int SIGW    = 18
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cmdValid,
  output logic            cmdReady,
  input  logic [1:0]      cmdOp,
  input  logic [SIGW-1:0] cmdSigNum,
  input  logic            mcInValid,
  output logic            mcInReady,
  output logic            loadInFifo,
  output logic            startF,
  output logic            startI,
  output logic            loadF,
  output logic            filter,
  output logic            loadFifoFromRam,
  output logic [SIGW-1:0] sigNum,
  input  logic            done,
  input  logic            calculating,
  input  logic            outFifoReady,
  input  logic            mcDataOutValid,
  output logic            respValid,
  input  logic            respReady,
  output logic [1:0]      respErr,
  output logic            busy
);

  localparam int BW = $clog2(BEATS + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
  localparam logic [TW-1:0] LAST_WAIT = TW'(TIMEOUT - 1);

  ctrl_state_t state, stateNext;
  fft_op_t     opReg;
  resp_err_t   errReg, errNext;
  logic        drainSeen;
  logic        cmdFire, drainGo;
  logic        beatEn, beatClr, beatLast;
  logic        toEn, toClr, toLast;
  logic [BW-1:0] beatCount;
  logic [TW-1:0] toCount;

  assign cmdReady   = (state == ST_IDLE);
  assign mcInReady  = (state == ST_LOAD);
  assign loadInFifo = mcInValid & mcInReady;
  assign respValid  = (state == ST_RESP);
  assign busy       = (state != ST_IDLE);
  assign respErr    = errReg;
  assign cmdFire    = cmdValid & cmdReady;

  // Once outFifoReady has been seen, drain beats count even if it drops again.
  assign drainGo  = outFifoReady | drainSeen;
  assign beatEn   = ((state == ST_LOAD) && mcInValid) ||
                    ((state == ST_DRAIN) && drainGo && mcDataOutValid);
  assign beatClr  = cmdFire || (state == ST_START);
  assign beatLast = beatEn && (beatCount == LAST_BEAT);
  assign toEn     = (state == ST_WAIT) || (state == ST_WAITF);
  assign toClr    = cmdFire || (state == ST_FILT);
  assign toLast   = toCount >= LAST_WAIT;

  ctrl_counter #(.WIDTH(BW), .MAXVAL(BEATS)) beatCounter (
    .clk(clk), .rst(rst), .clr(beatClr), .load(1'b0), .loadVal('0),
    .en(beatEn), .count(beatCount)
  );

  ctrl_counter #(.WIDTH(TW), .MAXVAL(TIMEOUT)) timeoutCounter (
    .clk(clk), .rst(rst), .clr(toClr), .load(1'b0), .loadVal('0),
    .en(toEn), .count(toCount)
  );

  always_comb begin
    stateNext = state;
    errNext   = errReg;
    unique case (state)
      ST_IDLE: begin
        if (cmdFire) begin
          if (cmdOp == OP_RSVD) begin
            stateNext = ST_RESP;
            errNext   = ERR_BAD_OP;
          end else begin
            stateNext = ST_LOAD;
          end
        end
      end
      ST_LOAD:  if (beatLast) stateNext = ST_START;
      ST_START: stateNext = ST_WAIT;
      ST_WAIT, ST_WAITF: begin
        // done has priority over an expiring timeout in the same cycle
        if (done) begin
          stateNext = ((state == ST_WAIT) && (opReg == OP_FFT_FILT)) ? ST_FILT : ST_UNLOAD;
        end else if (toLast) begin
          stateNext = ST_RESP;
          errNext   = ERR_TIMEOUT;
        end
      end
      ST_FILT:   stateNext = ST_WAITF;
      ST_UNLOAD: stateNext = ST_DRAIN;
      ST_DRAIN: begin
        if (beatLast) begin
          stateNext = ST_RESP;
          errNext   = ERR_OK;
        end
      end
      ST_RESP:  if (respReady) stateNext = ST_IDLE;
      default:  stateNext = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= ST_IDLE;
      opReg           <= OP_FFT;
      errReg          <= ERR_OK;
      sigNum          <= '0;
      drainSeen       <= 1'b0;
      startF          <= 1'b0;
      startI          <= 1'b0;
      loadF           <= 1'b0;
      filter          <= 1'b0;
      loadFifoFromRam <= 1'b0;
    end else begin
      state     <= stateNext;
      errReg    <= errNext;
      drainSeen <= (state == ST_DRAIN) && drainGo;
      if (cmdFire) begin
        opReg  <= fft_op_t'(cmdOp);
        sigNum <= cmdSigNum;
      end
      // Single-cycle states make these pulses one cycle wide by construction.
      startF          <= (state == ST_START) && (opReg != OP_IFFT);
      startI          <= (state == ST_START) && (opReg == OP_IFFT);
      loadF           <= (state == ST_FILT);
      filter          <= (state == ST_FILT);
      loadFifoFromRam <= (state == ST_UNLOAD);
    end
  end

endmodule

// File: tb/tb_fft_accel_ctrl.sv
// Self-checking bench for fft_accel_ctrl: directed jobs plus a per-cycle
// behavioural reference of the sequencing rules.
module tb_fft_accel_ctrl;

  localparam int BEATS   = 64;
  localparam int TIMEOUT = 200;
  localparam int SIGW    = 18;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic cmdValid = 1'b0, cmdReady;
  logic [1:0] cmdOp = 2'd0;
  logic [SIGW-1:0] cmdSigNum = '0;
  logic mcInValid = 1'b0, mcInReady, loadInFifo;
  logic startF, startI, loadF, filter, loadFifoFromRam;
  logic [SIGW-1:0] sigNum;
  logic done = 1'b0, calculating = 1'b0, outFifoReady = 1'b1, mcDataOutValid = 1'b1;
  logic respValid, respReady = 1'b0;
  logic [1:0] respErr;
  logic busy;

  always #5 clk = ~clk;

  fft_accel_ctrl #(.BEATS(BEATS), .TIMEOUT(TIMEOUT), .SIGW(SIGW)) dut (
    .clk(clk), .rst(rst),
    .cmdValid(cmdValid), .cmdReady(cmdReady), .cmdOp(cmdOp), .cmdSigNum(cmdSigNum),
    .mcInValid(mcInValid), .mcInReady(mcInReady), .loadInFifo(loadInFifo),
    .startF(startF), .startI(startI), .loadF(loadF), .filter(filter),
    .loadFifoFromRam(loadFifoFromRam), .sigNum(sigNum),
    .done(done), .calculating(calculating), .outFifoReady(outFifoReady),
    .mcDataOutValid(mcDataOutValid),
    .respValid(respValid), .respReady(respReady), .respErr(respErr), .busy(busy)
  );

  int nChecks = 0;
  int nFail   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    nChecks++;
    if (act != exp) begin
      nFail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference job phases (bench-local numbering)
  localparam int P_IDLE = 0, P_LOAD = 1, P_START = 2, P_WAIT = 3, P_FILT = 4,
                 P_WAITF = 5, P_UNLOAD = 6, P_DRAIN = 7, P_RESP = 8;

  int mPhase = P_IDLE, mOp = 0, mErr = 0, mBeats = 0, mWaited = 0, mDrained = 0;
  bit mArmed = 0;
  logic [SIGW-1:0] mSig = '0;
  bit eStartF = 0, eStartI = 0, eFilt = 0, eUnload = 0;

  int cyc = 0;
  int cntLoadIn = 0, cntStartF = 0, cntStartI = 0, cntBoth = 0, cntLoneF = 0;
  int cntLffr = 0, cntMcReady = 0, cntResp = 0;
  int lastAccept = 0, lastResp = 0, lastStart = 0, lastLoadF = 0, lastLffr = 0;
  int errAtResp = 0;
  logic [SIGW-1:0] sigAtResp = '0;
  bit prevResp = 0;

  initial forever begin
    @(negedge clk);
    cyc++;
    if (!rst) begin
      mPhase = P_IDLE; mSig = '0; mErr = 0;
      eStartF = 0; eStartI = 0; eFilt = 0; eUnload = 0; prevResp = 0;
      check("rst_pulses", {startF, startI, loadF, filter, loadFifoFromRam}, 0);
      check("rst_handshake", {mcInReady, loadInFifo, respValid, busy}, 0);
      check("rst_sigNum", sigNum, 0);
      check("rst_respErr", respErr, 0);
    end else begin
      check("cmdReady", cmdReady, mPhase == P_IDLE);
      check("busy", busy, mPhase != P_IDLE);
      check("mcInReady", mcInReady, mPhase == P_LOAD);
      check("loadInFifo", loadInFifo, (mPhase == P_LOAD) && mcInValid);
      check("respValid", respValid, mPhase == P_RESP);
      check("startF", startF, eStartF);
      check("startI", startI, eStartI);
      check("loadF", loadF, eFilt);
      check("filter", filter, eFilt);
      check("loadFifoFromRam", loadFifoFromRam, eUnload);
      check("sigNum", sigNum, mSig);
      if (mPhase == P_RESP) check("respErr", respErr, mErr);

      if (cmdValid && cmdReady) lastAccept = cyc;
      if (respValid && !prevResp) begin
        cntResp++; lastResp = cyc; errAtResp = respErr; sigAtResp = sigNum;
      end
      prevResp = respValid;
      if (loadInFifo) cntLoadIn++;
      if (mcInReady) cntMcReady++;
      if (startF) begin cntStartF++; lastStart = cyc; end
      if (startI) begin cntStartI++; lastStart = cyc; end
      if (loadF && filter) begin cntBoth++; lastLoadF = cyc; end
      if (loadF != filter) cntLoneF++;
      if (loadFifoFromRam) begin cntLffr++; lastLffr = cyc; end

      // advance the reference to the next cycle
      eStartF = 0; eStartI = 0; eFilt = 0; eUnload = 0;
      case (mPhase)
        P_IDLE: if (cmdValid) begin
          mSig = cmdSigNum; mOp = cmdOp;
          if (cmdOp == 2'd3) begin mErr = 2; mPhase = P_RESP; end
          else begin mBeats = 0; mPhase = P_LOAD; end
        end
        P_LOAD: if (mcInValid) begin
          mBeats++;
          if (mBeats == BEATS) mPhase = P_START;
        end
        P_START: begin
          eStartI = (mOp == 1); eStartF = (mOp != 1); mWaited = 0; mPhase = P_WAIT;
        end
        P_WAIT, P_WAITF: begin
          if (done) mPhase = (mPhase == P_WAIT && mOp == 2) ? P_FILT : P_UNLOAD;
          else begin
            mWaited++;
            if (mWaited == TIMEOUT) begin mErr = 1; mPhase = P_RESP; end
          end
        end
        P_FILT: begin eFilt = 1; mWaited = 0; mPhase = P_WAITF; end
        P_UNLOAD: begin eUnload = 1; mDrained = 0; mArmed = 0; mPhase = P_DRAIN; end
        P_DRAIN: begin
          if (outFifoReady) mArmed = 1;
          if (mArmed && mcDataOutValid) begin
            mDrained++;
            if (mDrained == BEATS) begin mErr = 0; mPhase = P_RESP; end
          end
        end
        P_RESP: if (respReady) mPhase = P_IDLE;
        default: mPhase = P_IDLE;
      endcase
    end
  end

  // Plays host, memory controller and accelerator for one job.
  task automatic runJob(input int op, input int sig, input bit toggle, input int w,
                        input int wf, input bit doneEn, input int ofrDelay,
                        input int respDelay, input int abortBeat);
    int beats = 0, dCount = 0, ofrCnt = 0, rdCnt = 0;
    bit handshook = 0, abortPending = 0;
    @(posedge clk); #1;
    cmdValid = 1'b1; cmdOp = op[1:0]; cmdSigNum = sig[SIGW-1:0];
    mcInValid = 1'b0; respReady = 1'b0;
    for (int budget = 0; budget < 3000; budget++) begin
      @(posedge clk); #1;
      if (abortPending) begin
        rst = 1'b0; cmdValid = 1'b0; mcInValid = 1'b0; done = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        return;
      end
      if (handshook) begin
        respReady = 1'b0; mcInValid = 1'b0; done = 1'b0; outFifoReady = 1'b1;
        return;
      end
      if (!cmdReady) cmdValid = 1'b0;
      mcInValid = toggle ? ~mcInValid : 1'b1;
      if (mcInValid && mcInReady) begin
        beats++;
        if (abortBeat > 0 && beats == abortBeat) abortPending = 1;
      end
      done = 1'b0;
      if (doneEn && dCount > 0) begin
        dCount--;
        if (dCount == 0) done = 1'b1;
      end
      if (mcInReady && beats == 10) done = 1'b1;
      if (startF || startI) dCount = w;
      if (loadF) dCount = wf;
      if (ofrDelay > 0) begin
        if (startF || startI) outFifoReady = 1'b0;
        if (loadFifoFromRam) ofrCnt = ofrDelay;
        else if (ofrCnt > 0) begin
          ofrCnt--;
          if (ofrCnt == 0) outFifoReady = 1'b1;
        end
      end
      if (respValid) begin
        if (rdCnt >= respDelay) begin respReady = 1'b1; handshook = 1; end
        else rdCnt++;
      end
    end
    nChecks++; nFail++;
    $display("FAIL job_timeout: got no response within 3000 cycles, required completion");
    cmdValid = 1'b0; respReady = 1'b0; outFifoReady = 1'b1; done = 1'b0;
  endtask

  int b0, f0, i0, bo0, lo0, l0, r0, m0;
  task automatic snap();
    b0 = cntLoadIn; f0 = cntStartF; i0 = cntStartI; bo0 = cntBoth;
    lo0 = cntLoneF; l0 = cntLffr; r0 = cntResp; m0 = cntMcReady;
  endtask

  task automatic report(input string tag);
    $display("job %s: accept=%0d resp=%0d latency=%0d err=%0d sig=%h beatsIn=%0d",
             tag, lastAccept, lastResp, lastResp - lastAccept, errAtResp, sigAtResp,
             cntLoadIn - b0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("reset_cmdReady", cmdReady, 1);
    check("reset_busy", busy, 0);
    check("reset_sigNum", sigNum, 0);
    check("reset_respErr", respErr, 0);

    // FFT, zero-stall, done 100 cycles after startF
    snap();
    runJob(0, 'h5, 0, 100, 0, 1, 0, 0, 0);
    report("fft");
    check("fft_loadInFifo_count", cntLoadIn - b0, 64);
    check("fft_startF_count", cntStartF - f0, 1);
    check("fft_startI_count", cntStartI - i0, 0);
    check("fft_lffr_count", cntLffr - l0, 1);
    check("fft_resp_count", cntResp - r0, 1);
    check("fft_respErr", errAtResp, 0);
    check("fft_sigNum", sigAtResp, 'h5);
    check("fft_latency", lastResp - lastAccept, 64 + 100 + 64 + 4);

    // IFFT, toggling input valid, delayed outFifoReady, stalled response
    snap();
    runJob(1, 'h2ABCD, 1, 40, 0, 1, 5, 4, 0);
    report("ifft");
    check("ifft_loadInFifo_count", cntLoadIn - b0, 64);
    check("ifft_startI_count", cntStartI - i0, 1);
    check("ifft_startF_count", cntStartF - f0, 0);
    check("ifft_lffr_count", cntLffr - l0, 1);
    check("ifft_respErr", errAtResp, 0);
    check("ifft_sigNum", sigAtResp, 'h2ABCD);

    // FFT then filter
    snap();
    runJob(2, 'h123, 0, 100, 50, 1, 0, 0, 0);
    report("fft_filt");
    check("filt_both_count", cntBoth - bo0, 1);
    check("filt_lone_count", cntLoneF - lo0, 0);
    check("filt_lffr_count", cntLffr - l0, 1);
    check("filt_lffr_after_loadF", lastLffr - lastLoadF, 50 + 2);
    check("filt_respErr", errAtResp, 0);
    check("filt_latency", lastResp - lastAccept, 64 + 100 + 64 + 4 + 2 + 50);

    // done never arrives
    snap();
    runJob(0, 'h77, 0, 0, 0, 0, 0, 0, 0);
    report("timeout");
    check("to_resp_after_start", lastResp - lastStart, 200);
    check("to_latency", lastResp - lastAccept, 266);
    check("to_respErr", errAtResp, 1);
    check("to_lffr_count", cntLffr - l0, 0);

    // reserved op
    snap();
    runJob(3, 'h3FFFF, 0, 0, 0, 0, 0, 0, 0);
    report("bad_op");
    check("badop_resp_delay", lastResp - lastAccept, 1);
    check("badop_respErr", errAtResp, 2);
    check("badop_mcInReady_count", cntMcReady - m0, 0);
    check("badop_start_count", (cntStartF - f0) + (cntStartI - i0), 0);

    // reset at input beat 30, then a fresh FFT
    snap();
    runJob(0, 'h9, 0, 20, 0, 1, 0, 0, 30);
    $display("job abort: beatsIn=%0d responses=%0d", cntLoadIn - b0, cntResp - r0);
    check("abort_beats", cntLoadIn - b0, 30);
    check("abort_no_resp", cntResp - r0, 0);
    snap();
    runJob(0, 'hA, 0, 20, 0, 1, 0, 0, 0);
    report("after_abort");
    check("rerun_loadInFifo_count", cntLoadIn - b0, 64);
    check("rerun_latency", lastResp - lastAccept, 64 + 20 + 64 + 4);
    check("rerun_respErr", errAtResp, 0);
    check("rerun_sigNum", sigAtResp, 'hA);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
